kl_mem_req_scheduler: RTL and testbench

- Shares one cache-line read port between two backward-extension pipelines.
- Each pipeline stage presents a (k, l) request pair, and the scheduler serializes it into one or two memory reads.
- If k and l fall in the same line, only one read is issued.
- Back-pressure to the pipelines is a per-requester stall: while stalled, the requester holds its request outputs stable.

---
 rtl/kl_mem_req_scheduler_if.sv | 39 +++
 rtl/kl_mem_req_scheduler.sv | 146 ++++++++++++++
 tb/tb_kl_mem_req_scheduler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/kl_mem_req_scheduler_if.sv
// Request/stall bundle from the two extension pipelines plus the shared
// cache-line read channel.
interface kl_mem_req_scheduler_if #(
  parameter int ADDR_W = 42,
  parameter int RN_W   = 8
);
  logic              req_valid_0;
  logic [ADDR_W-1:0] req_addr_k_0;
  logic [ADDR_W-1:0] req_addr_l_0;
  logic [RN_W-1:0]   req_read_num_0;
  logic              stall_0;

  logic              req_valid_1;
  logic [ADDR_W-1:0] req_addr_k_1;
  logic [ADDR_W-1:0] req_addr_l_1;
  logic [RN_W-1:0]   req_read_num_1;
  logic              stall_1;

  logic              mem_rd_valid;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [RN_W+2:0]   mem_rd_tag;
  logic              mem_rd_ready;

  modport master (
    output req_valid_0, req_addr_k_0, req_addr_l_0, req_read_num_0,
    output req_valid_1, req_addr_k_1, req_addr_l_1, req_read_num_1,
    input  stall_0, stall_1,
    input  mem_rd_valid, mem_rd_addr, mem_rd_tag,
    output mem_rd_ready
  );

  modport slave (
    input  req_valid_0, req_addr_k_0, req_addr_l_0, req_read_num_0,
    input  req_valid_1, req_addr_k_1, req_addr_l_1, req_read_num_1,
    output stall_0, stall_1,
    output mem_rd_valid, mem_rd_addr, mem_rd_tag,
    input  mem_rd_ready
  );
endinterface

// File: rtl/kl_mem_req_scheduler.sv
// Serializes (k, l) line-read pairs from two requesters onto one memory read
// port, merging same-line pairs into a single beat; round-robin fair.
module kl_mem_req_scheduler #(
  parameter int ADDR_W = 42,
  parameter int RN_W   = 8,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  kl_mem_req_scheduler_if.slave bus,
  output logic [CNT_W-1:0]      cnt_issued,
  output logic [CNT_W-1:0]      cnt_merged
);

  typedef enum logic [1:0] {IDLE, ISSUE_K, ISSUE_L, ISSUE_KL} state_t;

  state_t            state, state_nxt;
  logic              gnt, gnt_nxt;
  logic              rr_ptr, rr_nxt;

  logic [1:0]        hold_valid;
  logic [ADDR_W-1:0] addr_k   [2];
  logic [ADDR_W-1:0] addr_l   [2];
  logic [RN_W-1:0]   read_num [2];

  logic [1:0]        req_valid;
  logic [ADDR_W-1:0] in_k  [2];
  logic [ADDR_W-1:0] in_l  [2];
  logic [RN_W-1:0]   in_rn [2];

  logic [1:0]        same_line;
  logic [1:0]        last_acc;
  logic [1:0]        stall;
  logic [1:0]        capture;
  logic              fire;
  logic              retire;

  always_comb begin
    req_valid = {bus.req_valid_1, bus.req_valid_0};
    in_k[0]   = bus.req_addr_k_0;
    in_k[1]   = bus.req_addr_k_1;
    in_l[0]   = bus.req_addr_l_0;
    in_l[1]   = bus.req_addr_l_1;
    in_rn[0]  = bus.req_read_num_0;
    in_rn[1]  = bus.req_read_num_1;
  end

  assign same_line = {addr_k[1] == addr_l[1], addr_k[0] == addr_l[0]};

  // The only input-to-output path: ready on a final beat releases the stall.
  assign fire     = bus.mem_rd_valid & bus.mem_rd_ready;
  assign retire   = fire & ((state == ISSUE_L) | (state == ISSUE_KL));
  assign last_acc = {retire & gnt, retire & ~gnt};
  assign stall    = hold_valid & ~last_acc;
  assign capture  = req_valid & ~stall;

  assign bus.stall_0 = stall[0];
  assign bus.stall_1 = stall[1];

  always_comb begin
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_addr  = '0;
    bus.mem_rd_tag   = '0;
    case (state)
      ISSUE_K: begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_addr  = addr_k[gnt];
        bus.mem_rd_tag   = {gnt, read_num[gnt], 2'b01};
      end
      ISSUE_L: begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_addr  = addr_l[gnt];
        bus.mem_rd_tag   = {gnt, read_num[gnt], 2'b10};
      end
      ISSUE_KL: begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_addr  = addr_k[gnt];
        bus.mem_rd_tag   = {gnt, read_num[gnt], 2'b11};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (|hold_valid) begin
          gnt_nxt   = hold_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
          rr_nxt    = ~gnt_nxt;
          state_nxt = same_line[gnt_nxt] ? ISSUE_KL : ISSUE_K;
        end
      end
      ISSUE_K: begin
        if (bus.mem_rd_ready) state_nxt = ISSUE_L;
      end
      ISSUE_L, ISSUE_KL: begin
        // Hand straight to a waiting peer so alternating traffic has no bubble.
        if (bus.mem_rd_ready) begin
          if (hold_valid[~gnt]) begin
            gnt_nxt   = ~gnt;
            rr_nxt    = gnt;
            state_nxt = same_line[~gnt] ? ISSUE_KL : ISSUE_K;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      rr_ptr     <= 1'b0;
      hold_valid <= '0;
      cnt_issued <= '0;
      cnt_merged <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      rr_ptr     <= rr_nxt;
      for (int i = 0; i < 2; i++) begin
        if (capture[i])       hold_valid[i] <= 1'b1;
        else if (last_acc[i]) hold_valid[i] <= 1'b0;
      end
      cnt_issued <= cnt_issued + CNT_W'(fire);
      cnt_merged <= cnt_merged + CNT_W'(retire & (state == ISSUE_KL));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (capture[i]) begin
        addr_k[i]   <= in_k[i];
        addr_l[i]   <= in_l[i];
        read_num[i] <= in_rn[i];
      end
    end
  end

endmodule

// File: tb/tb_kl_mem_req_scheduler.sv
// Directed bench for kl_mem_req_scheduler: cycle table plus back-pressure
// and counter-wrap sequences.
module tb_kl_mem_req_scheduler;
  localparam int ADDR_W = 42;
  localparam int RN_W   = 8;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [CNT_W-1:0] cnt_issued, cnt_merged;

  int checks = 0;
  int errors = 0;

  kl_mem_req_scheduler_if #(.ADDR_W(ADDR_W), .RN_W(RN_W)) bus ();

  kl_mem_req_scheduler #(.ADDR_W(ADDR_W), .RN_W(RN_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .cnt_issued (cnt_issued),
    .cnt_merged (cnt_merged)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r;
    bit v0; int k0; int l0; int rn0;
    bit v1; int k1; int l1; int rn1;
    bit rdy;
    bit ev; int ea; int et;
    bit s0; bit s1;
    int ci; int cm;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic int tg(input int id, input int rn, input int kind);
    return (id << 10) | (rn << 2) | kind;
  endfunction

  function automatic vec_t mk(input bit r, input bit v0, input int k0, input int l0, input int rn0,
                              input bit v1, input int k1, input int l1, input int rn1, input bit rdy,
                              input bit ev, input int ea, input int et, input bit s0, input bit s1,
                              input int ci, input int cm);
    vec_t t;
    t.r = r; t.v0 = v0; t.k0 = k0; t.l0 = l0; t.rn0 = rn0;
    t.v1 = v1; t.k1 = k1; t.l1 = l1; t.rn1 = rn1; t.rdy = rdy;
    t.ev = ev; t.ea = ea; t.et = et; t.s0 = s0; t.s1 = s1; t.ci = ci; t.cm = cm;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set0(input bit v, input int k, input int l, input int rn);
    bus.req_valid_0    = v;
    bus.req_addr_k_0   = ADDR_W'(k);
    bus.req_addr_l_0   = ADDR_W'(l);
    bus.req_read_num_0 = RN_W'(rn);
  endtask

  task automatic set1(input bit v, input int k, input int l, input int rn);
    bus.req_valid_1    = v;
    bus.req_addr_k_1   = ADDR_W'(k);
    bus.req_addr_l_1   = ADDR_W'(l);
    bus.req_read_num_1 = RN_W'(rn);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    bus.mem_rd_ready = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
  endtask

  initial begin
    int beats;

    // Single pair from requester 0, then a merged pair from requester 1.
    vecs[0]  = mk(1, 1,'h100,'h105,3, 0,0,0,0, 1, 0,0,0,                 0,0, 0,0);
    vecs[1]  = mk(1, 0,0,0,0,         0,0,0,0, 1, 0,0,0,                 1,0, 0,0);
    vecs[2]  = mk(1, 0,0,0,0,         0,0,0,0, 1, 1,'h100,tg(0,3,1),     1,0, 0,0);
    vecs[3]  = mk(1, 0,0,0,0,         0,0,0,0, 1, 1,'h105,tg(0,3,2),     0,0, 1,0);
    vecs[4]  = mk(1, 0,0,0,0,         0,0,0,0, 1, 0,0,0,                 0,0, 2,0);
    vecs[5]  = mk(0, 0,0,0,0,         0,0,0,0, 1, 0,0,0,                 0,0, 2,0);
    vecs[6]  = mk(1, 0,0,0,0, 1,'h2A0,'h2A0,7, 1, 0,0,0,                 0,0, 0,0);
    vecs[7]  = mk(1, 0,0,0,0,         0,0,0,0, 1, 0,0,0,                 0,1, 0,0);
    vecs[8]  = mk(1, 0,0,0,0,         0,0,0,0, 1, 1,'h2A0,tg(1,7,3),     0,0, 0,0);
    vecs[9]  = mk(1, 0,0,0,0,         0,0,0,0, 1, 0,0,0,                 0,0, 1,1);
    vecs[10] = mk(0, 0,0,0,0,         0,0,0,0, 1, 0,0,0,                 0,0, 1,1);
    // Contention with both requesters continuously presenting.
    vecs[11] = mk(1, 1,'h10,'h11,1, 1,'h20,'h21,2, 1, 0,0,0,             0,0, 0,0);
    vecs[12] = mk(1, 1,'h10,'h11,1, 1,'h20,'h21,2, 1, 0,0,0,             1,1, 0,0);
    vecs[13] = mk(1, 1,'h10,'h11,1, 1,'h20,'h21,2, 1, 1,'h10,tg(0,1,1),  1,1, 0,0);
    vecs[14] = mk(1, 1,'h10,'h11,1, 1,'h20,'h21,2, 1, 1,'h11,tg(0,1,2),  0,1, 1,0);
    vecs[15] = mk(1, 1,'h10,'h11,1, 1,'h20,'h21,2, 1, 1,'h20,tg(1,2,1),  1,1, 2,0);
    vecs[16] = mk(1, 1,'h10,'h11,1, 1,'h20,'h21,2, 1, 1,'h21,tg(1,2,2),  1,0, 3,0);
    vecs[17] = mk(1, 1,'h10,'h11,1, 1,'h20,'h21,2, 1, 1,'h10,tg(0,1,1),  1,1, 4,0);
    vecs[18] = mk(1, 1,'h10,'h11,1, 1,'h20,'h21,2, 1, 1,'h11,tg(0,1,2),  0,1, 5,0);
    vecs[19] = mk(1, 1,'h10,'h11,1, 1,'h20,'h21,2, 1, 1,'h20,tg(1,2,1),  1,1, 6,0);
    // Reset lands while requester 1 is in its L beat with both entries full.
    vecs[20] = mk(0, 0,0,0,0,         0,0,0,0, 0, 1,'h21,tg(1,2,2),     1,1, 7,0);
    vecs[21] = mk(1, 0,0,0,0,         0,0,0,0, 1, 0,0,0,                 0,0, 0,0);
    vecs[22] = mk(1, 1,'h30,'h31,5,   0,0,0,0, 1, 0,0,0,                 0,0, 0,0);
    vecs[23] = mk(1, 0,0,0,0,         0,0,0,0, 1, 0,0,0,                 1,0, 0,0);
    vecs[24] = mk(1, 0,0,0,0,         0,0,0,0, 1, 1,'h30,tg(0,5,1),      1,0, 0,0);
    vecs[25] = mk(1, 0,0,0,0,         0,0,0,0, 1, 1,'h31,tg(0,5,2),      0,0, 1,0);
    vecs[26] = mk(1, 0,0,0,0,         0,0,0,0, 1, 0,0,0,                 0,0, 2,0);

    do_reset();

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].r;
      set0(vecs[i].v0, vecs[i].k0, vecs[i].l0, vecs[i].rn0);
      set1(vecs[i].v1, vecs[i].k1, vecs[i].l1, vecs[i].rn1);
      bus.mem_rd_ready = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), 64'(bus.mem_rd_valid), 64'(vecs[i].ev));
      chk($sformatf("v%0d_addr", i),  64'(bus.mem_rd_addr),  64'(vecs[i].ea));
      chk($sformatf("v%0d_tag", i),   64'(bus.mem_rd_tag),   64'(vecs[i].et));
      chk($sformatf("v%0d_stall0", i), 64'(bus.stall_0),     64'(vecs[i].s0));
      chk($sformatf("v%0d_stall1", i), 64'(bus.stall_1),     64'(vecs[i].s1));
      chk($sformatf("v%0d_cnt_issued", i), 64'(cnt_issued), 64'(vecs[i].ci));
      chk($sformatf("v%0d_cnt_merged", i), 64'(cnt_merged), 64'(vecs[i].cm));
      cyc();
    end

    // Back-pressure on the K beat; a new request waits behind the stall.
    do_reset();
    set0(1, 'h100, 'h105, 3);
    bus.mem_rd_ready = 1'b0;
    cyc();
    set0(0, 0, 0, 0);
    cyc();
    set0(1, 'h200, 'h201, 4);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", n),  64'(bus.mem_rd_valid), 64'd1);
      chk($sformatf("bp%0d_addr", n),   64'(bus.mem_rd_addr),  64'h100);
      chk($sformatf("bp%0d_tag", n),    64'(bus.mem_rd_tag),   64'(tg(0,3,1)));
      chk($sformatf("bp%0d_stall0", n), 64'(bus.stall_0),      64'd1);
      cyc();
    end
    bus.mem_rd_ready = 1'b1;
    @(negedge clk);
    chk("bp_k_accept_addr",   64'(bus.mem_rd_addr), 64'h100);
    chk("bp_k_accept_stall0", 64'(bus.stall_0),     64'd1);
    cyc();
    @(negedge clk);
    chk("bp_l_addr",   64'(bus.mem_rd_addr), 64'h105);
    chk("bp_l_tag",    64'(bus.mem_rd_tag),  64'(tg(0,3,2)));
    chk("bp_l_stall0", 64'(bus.stall_0),     64'd0);
    cyc();
    set0(0, 0, 0, 0);
    @(negedge clk);
    chk("bp_bubble_valid",  64'(bus.mem_rd_valid), 64'd0);
    chk("bp_bubble_stall0", 64'(bus.stall_0),      64'd1);
    cyc();
    @(negedge clk);
    chk("bp_new_k_addr", 64'(bus.mem_rd_addr), 64'h200);
    chk("bp_new_k_tag",  64'(bus.mem_rd_tag),  64'(tg(0,4,1)));
    cyc();
    cyc();
    @(negedge clk);
    chk("bp_cnt_issued", 64'(cnt_issued),       64'd4);
    chk("bp_end_valid",  64'(bus.mem_rd_valid), 64'd0);

    // Ready toggling in IDLE must not count; then 17 merged beats wrap to 1.
    do_reset();
    for (int n = 0; n < 6; n++) begin
      bus.mem_rd_ready = n[0];
      @(negedge clk);
      chk($sformatf("idle%0d_valid", n), 64'(bus.mem_rd_valid), 64'd0);
      cyc();
    end
    chk("idle_cnt_issued", 64'(cnt_issued), 64'd0);
    chk("idle_cnt_merged", 64'(cnt_merged), 64'd0);

    set0(1, 'h40, 'h40, 9);
    bus.mem_rd_ready = 1'b1;
    beats = 0;
    for (int n = 0; n < 200 && beats < 17; n++) begin
      @(negedge clk);
      if (bus.mem_rd_valid && bus.mem_rd_ready) begin
        beats++;
        if (beats == 17) set0(0, 0, 0, 0);
      end
      cyc();
    end
    chk("wrap_beats_seen", 64'(beats), 64'd17);
    cyc();
    @(negedge clk);
    chk("wrap_cnt_issued", 64'(cnt_issued),       64'd1);
    chk("wrap_cnt_merged", 64'(cnt_merged),       64'd1);
    chk("wrap_end_valid",  64'(bus.mem_rd_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
